// File: rtl/sel_pipe_mux_pkg.sv
// ============================================================================
// sel_pipe_mux_pkg : shared state encoding and NUM_IN bounds for sel_pipe_mux
// Revision: 1.0
// ============================================================================
`default_nettype none

package sel_pipe_mux_pkg;

   localparam int NUM_IN_MIN = 2;
   localparam int NUM_IN_MAX = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/sel_pipe_mux_mux.sv
// ============================================================================
// mux_n : combinational N-way word select; out-of-range selects saturate to the last input
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_n #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 5,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [WIDTH-1:0]        data_o,
   output logic [SEL_W-1:0]        sel_o,
   output logic                    err_o
);

   localparam logic [SEL_W:0]   C_NUM_IN = (SEL_W + 1)'(NUM_IN);
   localparam logic [SEL_W-1:0] C_LAST   = SEL_W'(NUM_IN - 1);

   logic [WIDTH-1:0] w_words [NUM_IN];
   logic             w_err;
   logic [SEL_W-1:0] w_sel;

   for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
      assign w_words[k] = data_i[k*WIDTH +: WIDTH];
   end

   always_comb begin
      w_err  = ({1'b0, sel_i} >= C_NUM_IN);
      w_sel  = w_err ? C_LAST : sel_i;
      data_o = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (w_sel == SEL_W'(k)) begin
            data_o = w_words[k];
         end
      end
   end

   assign sel_o = w_sel;
   assign err_o = w_err;

endmodule

`default_nettype wire

// File: rtl/sel_pipe_mux.sv
// ============================================================================
// sel_pipe_mux : registered N-way select behind a 2-entry skid buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module sel_pipe_mux
   import sel_pipe_mux_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 5,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
      $error("sel_pipe_mux: NUM_IN=%0d outside legal range", NUM_IN);
   end

   state_e           state_q, state_d;
   logic             in_ready_q;
   logic [WIDTH-1:0] main_data_q, skid_data_q;
   logic [SEL_W-1:0] main_sel_q,  skid_sel_q;
   logic             main_err_q,  skid_err_q;

   logic [WIDTH-1:0] w_mux_data;
   logic [SEL_W-1:0] w_mux_sel;
   logic             w_mux_err;
   logic             w_acc, w_pop;
   logic             w_load_main_new, w_load_main_skid, w_load_skid;

   mux_n #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_mux (
      .data_i (in_data),
      .sel_i  (sel),
      .data_o (w_mux_data),
      .sel_o  (w_mux_sel),
      .err_o  (w_mux_err)
   );

   assign w_acc = in_valid & in_ready_q;
   assign w_pop = out_valid & out_ready;

   // in_ready is registered from the next state so out_ready never reaches it combinationally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_FULL);
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (w_acc) state_d = ST_ONE;
            ST_ONE: begin
               if (w_acc && !w_pop)      state_d = ST_FULL;
               else if (w_pop && !w_acc) state_d = ST_EMPTY;
            end
            ST_FULL:  if (w_pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid        = (state_q != ST_EMPTY);
      w_load_main_new  = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (!flush) begin
         case (state_q)
            ST_EMPTY: w_load_main_new = w_acc;
            ST_ONE: begin
               w_load_main_new = w_acc & w_pop;
               w_load_skid     = w_acc & ~w_pop;
            end
            ST_FULL:  w_load_main_skid = w_pop;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_data_q <= '0;
         main_sel_q  <= '0;
         main_err_q  <= 1'b0;
      end else if (w_load_main_new) begin
         main_data_q <= w_mux_data;
         main_sel_q  <= w_mux_sel;
         main_err_q  <= w_mux_err;
      end else if (w_load_main_skid) begin
         main_data_q <= skid_data_q;
         main_sel_q  <= skid_sel_q;
         main_err_q  <= skid_err_q;
      end
   end

   // Skid contents are only meaningful in FULL, so they carry no reset
   always_ff @(posedge clk) begin
      if (w_load_skid) begin
         skid_data_q <= w_mux_data;
         skid_sel_q  <= w_mux_sel;
         skid_err_q  <= w_mux_err;
      end
   end

   assign in_ready = in_ready_q;
   assign out_data = main_data_q;
   assign out_sel  = main_sel_q;
   assign out_err  = main_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sel_pipe_mux.sv
// ============================================================================
// tb_sel_pipe_mux : directed and random stimulus against a queue-based FIFO model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sel_pipe_mux;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 5;
   localparam int SEL_W  = 3;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;

   sel_pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic [SEL_W-1:0] s;
      logic             e;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic set_std_words();
      for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
   endtask

   // Check current outputs against the model, apply one cycle of inputs, advance the model.
   task automatic step(input logic iv, input logic [SEL_W-1:0] s, input logic ordy,
                       input logic fl, input logic rn);
      exp_t e;
      int   eff;
      logic acc, pop;
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("out_data", out_data, q[0].d);
         chk("out_sel", out_sel, q[0].s);
         chk("out_err", out_err, q[0].e);
      end
      in_valid = iv; sel = s; out_ready = ordy; flush = fl; rst_n = rn;
      @(posedge clk);
      if (!rn || fl) begin
         q.delete();
      end else begin
         acc = iv && (q.size() < 2);
         pop = ordy && (q.size() > 0);
         if (pop) void'(q.pop_front());
         if (acc) begin
            eff  = (int'(s) < NUM_IN) ? int'(s) : NUM_IN - 1;
            e.d  = in_data[eff*WIDTH +: WIDTH];
            e.s  = SEL_W'(eff);
            e.e  = (int'(s) >= NUM_IN);
            q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_out_err", out_err, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; sel = '0; out_ready = 1'b0; flush = 1'b0;
      set_std_words();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_outputs();

      // Basic select and saturation
      step(1, 3'd3, 1, 0, 1);
      chk("basic_data", out_data, 32'h1000_0003);
      step(1, 3'd6, 1, 0, 1);
      chk("sat_data", out_data, 32'h1000_0004);
      chk("sat_err", out_err, 1);
      step(1, 3'd7, 1, 0, 1);
      step(0, 3'd0, 1, 0, 1);

      // Backpressure: 0 and 1 accepted, 2 stalls until the buffer drains
      step(1, 3'd0, 0, 0, 1);
      step(1, 3'd1, 0, 0, 1);
      chk("bp_in_ready", in_ready, 0);
      step(1, 3'd2, 0, 0, 1);
      chk("bp_hold", out_data, 32'h1000_0000);
      step(1, 3'd2, 1, 0, 1);
      step(1, 3'd2, 1, 0, 1);
      step(0, 3'd0, 1, 0, 1);
      step(0, 3'd0, 1, 0, 1);

      // Streaming
      for (int i = 0; i < 20; i++) step(1, SEL_W'(i % 5), 1, 0, 1);
      step(0, 3'd0, 1, 0, 1);
      step(0, 3'd0, 1, 0, 1);

      // Flush while FULL with a word on offer
      step(1, 3'd0, 0, 0, 1);
      step(1, 3'd1, 0, 0, 1);
      step(1, 3'd2, 0, 1, 1);
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      step(0, 3'd0, 1, 0, 1);

      // Reset while FULL
      step(1, 3'd1, 0, 0, 1);
      step(1, 3'd2, 0, 0, 1);
      step(1, 3'd3, 0, 0, 0);
      chk_reset_outputs();
      step(1, 3'd4, 1, 0, 1);
      chk("post_rst_data", out_data, 32'h1000_0004);
      step(0, 3'd0, 1, 0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
         step(($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 7)),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 63) != 0));
      end
      step(0, 3'd0, 1, 0, 1);
      step(0, 3'd0, 1, 0, 1);
      step(0, 3'd0, 1, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
